win_counter: RTL and testbench

//   Counts rounds won by one Tug-of-War player and drives the 3-bit value consumed by the seg7 HEX decoder.

---
 rtl/win_counter_if.sv | 10 +
 rtl/win_counter.sv | 112 +++++++++++
 tb/tb_win_counter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/win_counter_if.sv
// Signals between the playfield (master) and one player's win counter (slave).
interface win_counter_if;
    logic       win_in;
    logic [2:0] count;
    logic       round_restart;
    logic       game_over;

    modport master (output win_in, input count, input round_restart, input game_over);
    modport slave  (input win_in, output count, output round_restart, output game_over);
endinterface

// File: rtl/win_counter.sv
// Tug-of-War round-win counter: edge-detects win_in, holds, pulses round_restart, freezes at MAX_WINS.
// Optional WIN_COUNTER_SYNC_EN adds a two-flop synchronizer on win_in ahead of the edge detect.
module win_counter #(
    parameter int MAX_WINS    = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    win_counter_if.slave  bus
);

    localparam int              HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [2:0]      MAX_C     = 3'(MAX_WINS);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {PLAY, HOLD, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          restart_q, restart_d;
    logic          game_over_q, game_over_d;
    logic          win_s;
    logic          win_q;
    logic          rise;

`ifdef WIN_COUNTER_SYNC_EN
    logic sync1_q, sync2_q;

    // Reset to 1 so a level already high at release cannot look like a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.win_in;
            sync2_q <= sync1_q;
        end
    end

    assign win_s = sync2_q;
`else
    assign win_s = bus.win_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= 1'b1;
        end else begin
            win_q <= win_s;
        end
    end

    assign rise = win_s & ~win_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLAY;
            count_q     <= 3'd0;
            hold_q      <= '0;
            restart_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            restart_q   <= restart_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hold_d      = hold_q;
        restart_d   = 1'b0;
        game_over_d = game_over_q;
        case (state_q)
            PLAY: begin
                if (rise) begin
                    count_d = count_q + 3'd1;
                    if (count_q + 3'd1 == MAX_C) begin
                        state_d     = DONE;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    restart_d = 1'b1;
                    state_d   = PLAY;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    assign bus.count         = count_q;
    assign bus.round_restart = restart_q;
    assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_win_counter.sv
// Self-checking bench for win_counter: per-cycle vector table with scoreboard, plus latency and MAX_WINS=1 sequences.
module tb_win_counter;

`ifdef WIN_COUNTER_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    typedef struct {
        logic       rst;
        logic       win;
        logic [2:0] cnt;
        logic       rr;
        logic       go;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    vec_t sb[$];

    win_counter_if bus0 ();
    win_counter_if bus1 ();

    win_counter #(.MAX_WINS(7), .HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    win_counter #(.MAX_WINS(1), .HOLD_CYCLES(4)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input int c, input logic rr, input logic go,
                       input int n = 1);
        vec_t v;
        v.rst = r;
        v.win = w;
        v.cnt = 3'(c);
        v.rr  = rr;
        v.go  = go;
        repeat (n) vecs.push_back(v);
    endtask

    // One-cycle win pulse in PLAY: count update, three hold cycles, restart pulse, idle.
    task automatic add_pulse(input int c);
        add(0, 1, c, 0, 0);
        add(0, 0, c, 0, 0, 3);
        add(0, 0, c, 1, 0);
        add(0, 0, c, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus0.win_in = 1'b0;
        bus1.win_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        vec_t e;
        reset       = 1'b1;
        bus0.win_in = 1'b0;
        bus1.win_in = 1'b0;

`ifndef WIN_COUNTER_SYNC_EN
        add(1, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0);
        add_pulse(1);
        // level held high for 20 cycles counts once
        add(0, 1, 2, 0, 0, 4);
        add(0, 1, 2, 1, 0);
        add(0, 1, 2, 0, 0, 15);
        add(0, 0, 2, 0, 0);
        // pulse inside HOLD is ignored
        add(0, 1, 3, 0, 0);
        add(0, 0, 3, 0, 0);
        add(0, 1, 3, 0, 0);
        add(0, 0, 3, 0, 0);
        add(0, 0, 3, 1, 0);
        add(0, 0, 3, 0, 0);
        // rise on the HOLD exit edge is ignored and never counted later
        add(0, 1, 4, 0, 0);
        add(0, 0, 4, 0, 0, 3);
        add(0, 1, 4, 1, 0);
        add(0, 1, 4, 0, 0);
        add(0, 0, 4, 0, 0);
        add_pulse(5);
        add_pulse(6);
        add(0, 1, 7, 0, 1);
        add(0, 0, 7, 0, 1, 5);
        add(0, 1, 7, 0, 1);
        add(0, 0, 7, 0, 1, 2);
        // reset two cycles into HOLD with count 3
        add(1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0);
        add_pulse(1);
        add_pulse(2);
        add(0, 1, 3, 0, 0);
        add(0, 0, 3, 0, 0, 2);
        add(1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 8);
        // win_in high through reset release is not counted
        add(1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0);
        add_pulse(1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset       = vecs[i].rst;
            bus0.win_in = vecs[i].win;
            sb.push_back(vecs[i]);
            if (vecs[i].rst) begin
                #1;
                check($sformatf("async_clear_count[%0d]", i), 8'(bus0.count), 8'd0);
                check($sformatf("async_clear_go[%0d]", i), 8'(bus0.game_over), 8'd0);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("count[%0d]", i), 8'(bus0.count), 8'(e.cnt));
            check($sformatf("round_restart[%0d]", i), 8'(bus0.round_restart), 8'(e.rr));
            check($sformatf("game_over[%0d]", i), 8'(bus0.game_over), 8'(e.go));
        end
`endif

        // win-to-count latency and restart spacing
        do_reset();
        check("reset_count", 8'(bus0.count), 8'd0);
        check("reset_go", 8'(bus0.game_over), 8'd0);
        bus0.win_in = 1'b1;
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus0.win_in = 1'b0;
            if (bus0.count == 3'd1) begin
                lat = k;
                break;
            end
        end
        check("win_to_count_latency", 8'(lat), 8'(1 + SYNC));
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (bus0.round_restart) begin
                lat = k;
                break;
            end
        end
        check("count_to_restart_spacing", 8'(lat), 8'd4);
        @(posedge clk);
        #1;
        check("restart_width", 8'(bus0.round_restart), 8'd0);
        check("latency_go", 8'(bus0.game_over), 8'd0);

        // MAX_WINS=1: first rise goes straight to game_over, no restart
        do_reset();
        @(negedge clk);
        bus1.win_in = 1'b1;
        @(negedge clk);
        bus1.win_in = 1'b0;
        repeat (SYNC) @(negedge clk);
        check("mw1_count", 8'(bus1.count), 8'd1);
        check("mw1_go", 8'(bus1.game_over), 8'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("mw1_no_restart[%0d]", k), 8'(bus1.round_restart), 8'd0);
        end
        @(negedge clk);
        bus1.win_in = 1'b1;
        repeat (3 + SYNC) @(negedge clk);
        check("mw1_frozen_count", 8'(bus1.count), 8'd1);
        check("mw1_frozen_go", 8'(bus1.game_over), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
